// File: rtl/hist_eq_engine.sv
// hist_eq_engine: two-pass histogram equaliser.
// Pass 1 clears the bins, accumulates the histogram and sweeps the CDF into a
// remap LUT. Pass 2 maps the re-streamed image through the LUT on a
// valid/ready stream with one-cycle latency.
// Optional macro HIST_READ_EN adds a registered histogram readback port.
module hist_eq_engine #(
  parameter int PIX_W     = 8,
  parameter int LOG2_NPIX = 16,
  parameter int CNT_W     = LOG2_NPIX + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_in_valid,
  input  logic [PIX_W-1:0] i_in_data,
  output logic             o_in_ready,
  output logic             o_out_valid,
  output logic [PIX_W-1:0] o_out_data,
  input  logic             i_out_ready,
  output logic             o_busy,
  output logic [2:0]       o_phase,
  output logic             o_done
`ifdef HIST_READ_EN
  ,
  input  logic [PIX_W-1:0] i_hist_rd_addr,
  output logic [CNT_W-1:0] o_hist_rd_data
`endif
);

  localparam int BINS   = 1 << PIX_W;
  localparam int NPIX   = 1 << LOG2_NPIX;
  localparam int SEQ_W  = PIX_W + 2;
  localparam int PROD_W = CNT_W + PIX_W;
  localparam logic [CNT_W-1:0]  LAST_PIX = CNT_W'(NPIX - 1);
  localparam logic [CNT_W-1:0]  ALL_PIX  = CNT_W'(NPIX);
  localparam logic [SEQ_W-1:0]  LAST_BIN = SEQ_W'(BINS - 1);
  localparam logic [SEQ_W-1:0]  NUM_BINS = SEQ_W'(BINS);
  localparam logic [SEQ_W-1:0]  CDF_END  = SEQ_W'(BINS + 1);
  localparam logic [PROD_W-1:0] BIN_MAX  = PROD_W'(BINS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ACCUM = 3'd2,
    S_CDF   = 3'd3,
    S_MAP   = 3'd4
  } state_t;

  // Histogram bins and remap LUT: plain arrays, never reset.
  logic [CNT_W-1:0] r_bin [BINS];
  logic [PIX_W-1:0] r_lut [BINS];

  state_t           r_state;
  logic [SEQ_W-1:0] r_seq;        // CLEAR / CDF sweep index
  logic [CNT_W-1:0] r_in_cnt;
  logic [CNT_W-1:0] r_out_cnt;
  logic             r_out_valid;
  logic [PIX_W-1:0] r_out_data;
  logic             r_done;
  // Accumulate pipeline: s1 = read returned, s2 = value just written.
  logic             r_s1_v;
  logic [PIX_W-1:0] r_s1_addr;
  logic             r_s2_v;
  logic [PIX_W-1:0] r_s2_addr;
  logic [CNT_W-1:0] r_s2_data;
  logic [CNT_W-1:0] r_bin_q;      // registered bin read data
  // CDF sweep: read returned for bin r_rd_idx.
  logic             r_rd_v;
  logic [PIX_W-1:0] r_rd_idx;
  logic [CNT_W-1:0] r_cdf;

  logic             w_in_ready;
  logic             w_in_hs;
  logic             w_out_hs;
  logic [CNT_W-1:0] w_fwd_data;
  logic [CNT_W-1:0] w_inc;
  logic [CNT_W-1:0] w_cdf_sum;
  logic [PROD_W-1:0] w_prod;
  logic [PIX_W-1:0] w_lut_val;
  logic             w_cdf_rd;
  logic             w_bin_we;
  logic [PIX_W-1:0] w_bin_waddr;
  logic [CNT_W-1:0] w_bin_wdata;
  logic             w_bin_re;
  logic [PIX_W-1:0] w_bin_raddr;

  assign w_in_ready = (r_state == S_ACCUM) ||
                      ((r_state == S_MAP) && (r_in_cnt != ALL_PIX) &&
                       (!r_out_valid || i_out_ready));
  assign w_in_hs    = i_in_valid && w_in_ready;
  assign w_out_hs   = r_out_valid && i_out_ready;

  // The previous increment lands in RAM on the same edge our read was taken,
  // so a back-to-back hit on the same bin takes the forwarded value instead.
  assign w_fwd_data = (r_s2_v && (r_s2_addr == r_s1_addr)) ? r_s2_data : r_bin_q;
  assign w_inc      = w_fwd_data + CNT_W'(1);

  assign w_cdf_sum  = r_cdf + r_bin_q;
  assign w_prod     = PROD_W'(w_cdf_sum) * BIN_MAX;
  assign w_lut_val  = PIX_W'(w_prod >> LOG2_NPIX);

  // CDF reads start one cycle into the phase so the final accumulate write
  // has already reached the RAM.
  assign w_cdf_rd   = (r_state == S_CDF) && (r_seq != '0) && (r_seq <= NUM_BINS);

  // Bin RAM port steering: CLEAR and the accumulate write-back never overlap.
  always_comb begin
    w_bin_we    = 1'b0;
    w_bin_waddr = '0;
    w_bin_wdata = '0;
    w_bin_re    = 1'b0;
    w_bin_raddr = '0;
    if (r_state == S_CLEAR) begin
      w_bin_we    = 1'b1;
      w_bin_waddr = r_seq[PIX_W-1:0];
    end
    if (r_s1_v) begin
      w_bin_we    = 1'b1;
      w_bin_waddr = r_s1_addr;
      w_bin_wdata = w_inc;
    end
    if (r_state == S_ACCUM) begin
      w_bin_re    = w_in_hs;
      w_bin_raddr = i_in_data;
    end else if (w_cdf_rd) begin
      w_bin_re    = 1'b1;
      w_bin_raddr = PIX_W'(r_seq - SEQ_W'(1));
    end
  end

  // RAM writes and registered reads for bins and LUT.
  always_ff @(posedge i_clk) begin
    if (w_bin_we) r_bin[w_bin_waddr] <= w_bin_wdata;
    if (w_bin_re) r_bin_q <= r_bin[w_bin_raddr];
    if (r_rd_v)   r_lut[r_rd_idx] <= w_lut_val;
  end

`ifdef HIST_READ_EN
  logic [CNT_W-1:0] r_hist_rd;
  // Histogram readback, one-cycle latency.
  always_ff @(posedge i_clk) begin
    r_hist_rd <= r_bin[i_hist_rd_addr];
  end
  assign o_hist_rd_data = r_hist_rd;
`endif

  // Main control FSM with registered stream outputs.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= S_IDLE;
      r_seq       <= '0;
      r_in_cnt    <= '0;
      r_out_cnt   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_done      <= 1'b0;
      r_s1_v      <= 1'b0;
      r_s1_addr   <= '0;
      r_s2_v      <= 1'b0;
      r_s2_addr   <= '0;
      r_s2_data   <= '0;
      r_rd_v      <= 1'b0;
      r_rd_idx    <= '0;
      r_cdf       <= '0;
    end else begin
      r_done    <= 1'b0;
      r_s1_v    <= 1'b0;
      r_rd_v    <= 1'b0;
      r_s2_v    <= r_s1_v;
      r_s2_addr <= r_s1_addr;
      r_s2_data <= w_inc;
      if (r_rd_v) r_cdf <= w_cdf_sum;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_CLEAR;
            r_seq   <= '0;
          end
        end
        S_CLEAR: begin
          r_seq <= r_seq + SEQ_W'(1);
          if (r_seq == LAST_BIN) begin
            r_state  <= S_ACCUM;
            r_seq    <= '0;
            r_in_cnt <= '0;
          end
        end
        S_ACCUM: begin
          if (w_in_hs) begin
            r_s1_v    <= 1'b1;
            r_s1_addr <= i_in_data;
            r_in_cnt  <= r_in_cnt + CNT_W'(1);
            if (r_in_cnt == LAST_PIX) begin
              r_state <= S_CDF;
              r_seq   <= '0;
              r_cdf   <= '0;
            end
          end
        end
        S_CDF: begin
          r_seq <= r_seq + SEQ_W'(1);
          if (w_cdf_rd) begin
            r_rd_v   <= 1'b1;
            r_rd_idx <= w_bin_raddr;
          end
          if (r_seq == CDF_END) begin
            r_state   <= S_MAP;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
          end
        end
        S_MAP: begin
          if (w_in_hs) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_lut[i_in_data];
            r_in_cnt    <= r_in_cnt + CNT_W'(1);
          end else if (w_out_hs) begin
            r_out_valid <= 1'b0;
          end
          if (w_out_hs) begin
            r_out_cnt <= r_out_cnt + CNT_W'(1);
            if (r_out_cnt == LAST_PIX) begin
              r_done      <= 1'b1;
              r_state     <= S_IDLE;
              r_out_valid <= 1'b0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_busy      = (r_state != S_IDLE);
  assign o_phase     = r_state;
  assign o_done      = r_done;

endmodule

// File: tb/tb_hist_eq_engine.sv
// Self-checking bench for hist_eq_engine with 16-pixel frames.
module tb_hist_eq_engine;
  localparam int PIX_W     = 8;
  localparam int LOG2_NPIX = 4;
  localparam int CNT_W     = LOG2_NPIX + 1;
  localparam int NPIX      = 16;
  localparam int CAP       = 3000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             in_valid = 1'b0;
  logic [PIX_W-1:0] in_data = '0;
  logic             out_ready = 1'b1;
  logic             o_in_ready;
  logic             o_out_valid;
  logic [PIX_W-1:0] o_out_data;
  logic             o_busy;
  logic [2:0]       o_phase;
  logic             o_done;
`ifdef HIST_READ_EN
  logic [PIX_W-1:0] hist_rd_addr = '0;
  logic [CNT_W-1:0] hist_rd_data;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  logic [PIX_W-1:0] img  [NPIX];
  logic [PIX_W-1:0] expv [NPIX];

  hist_eq_engine #(.PIX_W(PIX_W), .LOG2_NPIX(LOG2_NPIX), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_start(start),
    .i_in_valid(in_valid), .i_in_data(in_data), .o_in_ready(o_in_ready),
    .o_out_valid(o_out_valid), .o_out_data(o_out_data), .i_out_ready(out_ready),
    .o_busy(o_busy), .o_phase(o_phase), .o_done(o_done)
`ifdef HIST_READ_EN
    , .i_hist_rd_addr(hist_rd_addr), .o_hist_rd_data(hist_rd_data)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (o_done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: histogram -> running CDF -> scaled LUT, then map the image.
  task automatic model_expect();
    int hist [256];
    int lut  [256];
    int cdf;
    foreach (hist[v]) hist[v] = 0;
    for (int k = 0; k < NPIX; k++) hist[img[k]]++;
    cdf = 0;
    for (int v = 0; v < 256; v++) begin
      cdf += hist[v];
      lut[v] = (cdf * 255) >> LOG2_NPIX;
    end
    for (int k = 0; k < NPIX; k++) expv[k] = lut[img[k]][PIX_W-1:0];
  endtask

  // Drive junk with in_valid high until the engine reaches the wanted phase.
  task automatic wait_phase(input string tag, input logic [2:0] ph);
    int cyc = 0;
    while (o_phase !== ph && cyc < 700) begin
      in_valid = 1'b1;
      in_data  = PIX_W'($urandom);
      @(negedge clk);
      cyc++;
    end
    check(tag, o_phase, ph);
  endtask

  // One pass of pixels; in MAP also collects and checks outputs in order.
  task automatic stream(input string name, input bit map_pass, input int gap,
                        input int bp, input int reset_after, output bit aborted);
    int idx = 0, outs = 0, cyc = 0, bp_left = 0, extra = 0;
    bit bp_used = 0, prev_stall = 0;
    logic [PIX_W-1:0] prev_data = '0;
    aborted = 0;
    while (((idx < NPIX) || (map_pass && outs < NPIX)) && cyc < CAP) begin
      if (reset_after >= 0 && idx == reset_after) begin
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", o_in_ready, 0);
        check("abort_out_valid", o_out_valid, 0);
        check("abort_out_data", o_out_data, 0);
        check("abort_busy", o_busy, 0);
        check("abort_phase", o_phase, 0);
        check("abort_done", o_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        aborted = 1;
        return;
      end
      if (idx < NPIX) begin
        in_valid = (gap == 0) ? 1'b1 : (gap == 1) ? (cyc % 2 == 0) : 1'($urandom);
        in_data  = img[idx];
      end else begin
        in_valid = map_pass;
        in_data  = PIX_W'($urandom);
      end
      if (bp == 1) begin
        if (!bp_used && o_out_valid && outs == 3) begin
          bp_left = 5;
          bp_used = 1;
        end
        out_ready = (bp_left == 0);
        if (bp_left > 0) bp_left--;
      end else if (bp == 2) begin
        out_ready = ($urandom % 3) != 0;
      end else begin
        out_ready = 1'b1;
      end
      #1;
      if (map_pass) begin
        if (prev_stall && o_out_valid) check({name, "_hold"}, o_out_data, prev_data);
        if (o_out_valid && !out_ready) check({name, "_stall_in_ready"}, o_in_ready, 0);
        prev_stall = o_out_valid && !out_ready;
        prev_data  = o_out_data;
        if (o_out_valid && out_ready) begin
          check($sformatf("%s_out%0d", name, outs), o_out_data, expv[outs]);
          outs++;
        end
      end
      if (in_valid && o_in_ready) begin
        if (idx < NPIX) idx++;
        else extra++;
      end
      cyc++;
      @(negedge clk);
    end
    check({name, map_pass ? "_map_in_time" : "_acc_in_time"}, (cyc < CAP), 1);
    if (map_pass) begin
      check({name, "_out_count"}, outs, NPIX);
      check({name, "_extra_accepts"}, extra, 0);
    end
  endtask

  task automatic run_frame(input string name, input int gap, input int bp,
                           input int reset_after);
    int d0;
    bit ab;
    d0 = done_cnt;
    in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_phase({name, "_reach_accum"}, 3'd2);
    stream(name, 1'b0, gap, bp, reset_after, ab);
    if (ab) return;
    wait_phase({name, "_reach_map"}, 3'd4);
    stream(name, 1'b1, gap, bp, -1, ab);
    in_valid = 1'b0;
    check({name, "_phase_idle"}, o_phase, 0);
    check({name, "_busy_low"}, o_busy, 0);
    check({name, "_out_valid_low"}, o_out_valid, 0);
    @(negedge clk);
    #1;
    check({name, "_done_pulses"}, done_cnt - d0, 1);
    $display("frame %s finished: compared=%0d mismatched=%0d", name, n_cmp, n_bad);
  endtask

  initial begin
    int j;
    logic [PIX_W-1:0] t;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", o_in_ready, 0);
    check("rst_out_valid", o_out_valid, 0);
    check("rst_out_data", o_out_data, 0);
    check("rst_busy", o_busy, 0);
    check("rst_phase", o_phase, 0);
    check("rst_done", o_done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Uniform image of 100 -> all 255.
    for (int k = 0; k < NPIX; k++) begin img[k] = 8'd100; expv[k] = 8'd255; end
    run_frame("uniform", 0, 0, -1);

    // Two-level image, shuffled order: 0 -> 127, 255 -> 255.
    for (int k = 0; k < NPIX; k++) img[k] = (k < 8) ? 8'd0 : 8'd255;
    for (int k = NPIX - 1; k > 0; k--) begin
      j = $urandom_range(k, 0);
      t = img[k]; img[k] = img[j]; img[j] = t;
    end
    for (int k = 0; k < NPIX; k++) expv[k] = (img[k] == 8'd0) ? 8'd127 : 8'd255;
    run_frame("twolevel", 0, 0, -1);
`ifdef HIST_READ_EN
    hist_rd_addr = 8'd0;
    @(negedge clk); #1;
    check("hist_rd_0", hist_rd_data, 8);
    hist_rd_addr = 8'd255;
    @(negedge clk); #1;
    check("hist_rd_255", hist_rd_data, 8);
    hist_rd_addr = 8'd100;
    @(negedge clk); #1;
    check("hist_rd_100", hist_rd_data, 0);
`endif

    // Ramp 0..15, first with alternating in_valid, then continuous.
    for (int k = 0; k < NPIX; k++) begin
      img[k]  = PIX_W'(k);
      expv[k] = PIX_W'(((k + 1) * 255) >> LOG2_NPIX);
    end
    run_frame("ramp_gap", 1, 0, -1);
    run_frame("ramp", 0, 0, -1);

    // Random image with a 5-cycle backpressure window.
    for (int k = 0; k < NPIX; k++) img[k] = PIX_W'($urandom_range(255, 0));
    model_expect();
    run_frame("rand_bp", 0, 1, -1);

    // Abort mid-ACCUM after 6 pixels, then a clean uniform frame.
    for (int k = 0; k < NPIX; k++) img[k] = PIX_W'($urandom_range(255, 0));
    run_frame("aborted", 0, 0, 6);
    for (int k = 0; k < NPIX; k++) begin img[k] = 8'd100; expv[k] = 8'd255; end
    run_frame("after_abort", 0, 0, -1);

    // Random frames with many repeats, random gaps and random backpressure.
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < NPIX; k++)
        img[k] = (f % 2 == 0) ? PIX_W'($urandom_range(3, 0)) : PIX_W'($urandom_range(255, 0));
      model_expect();
      run_frame($sformatf("rand%0d", f), 2, 2, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
